// File: rtl/ctrl_pipe_chain.sv
// ctrl_pipe_chain
//   Parametrised control-word pipeline. A WIDTH-bit decoded control word and
//   its valid bit move through DEPTH stages. Each stage can be stalled or
//   flushed. A stall holds that stage and every stage upstream of it, and a
//   bubble is inserted just downstream of the held run. Selected bits of the
//   word are killed by cond_ex as the word leaves COND_STAGE.
//
//   Optional build macro: CTRL_PIPE_PERF_EN adds the saturating bubble_cnt
//   and flush_cnt performance counters.
//
//   reset is asynchronous and active-low.
module ctrl_pipe_chain #(
  parameter int               WIDTH      = 31,
  parameter int               DEPTH      = 3,
  parameter int               COND_STAGE = 0,
  parameter logic [WIDTH-1:0] KILL_MASK  = 'h0000B
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_ctrl,
  output logic                   in_ready,
  input  logic [DEPTH-1:0]       stall,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   cond_ex,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_ctrl,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_ctrl
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [15:0]            bubble_cnt,
  output logic [15:0]            flush_cnt
`endif
);

  logic [DEPTH-1:0] hold;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [WIDTH-1:0] ctrl_q [DEPTH];
  logic [WIDTH-1:0] ctrl_d [DEPTH];
  logic [WIDTH-1:0] kill_vec;

  // A stall anywhere downstream holds this stage; accumulate from the tail.
  always_comb begin
    logic acc;
    acc  = 1'b0;
    hold = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc     = acc | stall[i];
      hold[i] = acc;
    end
  end

  assign kill_vec = KILL_MASK & {WIDTH{~cond_ex}};
  assign in_ready = ~hold[0];

  // Next contents of every stage: flush, then hold, then bubble, then load.
  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) begin
      ctrl_d[i] = ctrl_q[i];
    end

    if (flush[0]) begin
      valid_d[0] = 1'b0;
      ctrl_d[0]  = '0;
    end else if (!hold[0]) begin
      valid_d[0] = in_valid;
      ctrl_d[0]  = in_ctrl;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
        ctrl_d[i]  = '0;
      end else if (hold[i]) begin
        valid_d[i] = valid_q[i];
        ctrl_d[i]  = ctrl_q[i];
      end else if (hold[i-1]) begin
        valid_d[i] = 1'b0;
        ctrl_d[i]  = '0;
      end else begin
        valid_d[i] = valid_q[i-1];
        // The word leaving COND_STAGE loses its condition-gated bits when
        // cond_ex is false; the valid bit is passed through untouched.
        if (i == COND_STAGE + 1) begin
          ctrl_d[i] = ctrl_q[i-1] & ~kill_vec;
        end else begin
          ctrl_d[i] = ctrl_q[i-1];
        end
      end
    end
  end

  // Stage registers; reset clears everything regardless of stall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= ctrl_d[i];
      end
    end
  end

  // Flatten the stage words onto the packed output bus.
  always_comb begin
    stage_ctrl = '0;
    for (int i = 0; i < DEPTH; i++) begin
      stage_ctrl[i*WIDTH +: WIDTH] = ctrl_q[i];
    end
  end

  assign stage_valid = valid_q;
  assign out_valid   = valid_q[DEPTH-1];
  assign out_ctrl    = ctrl_q[DEPTH-1];

`ifdef CTRL_PIPE_PERF_EN
  logic last_loads_bubble;

  // The last stage takes an invalid word via bubble insertion or a normal load.
  assign last_loads_bubble = ~flush[DEPTH-1] & ~hold[DEPTH-1] &
                             (hold[DEPTH-2] | ~valid_q[DEPTH-2]);

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
      flush_cnt  <= '0;
    end else begin
      if (last_loads_bubble && (bubble_cnt != 16'hFFFF)) begin
        bubble_cnt <= bubble_cnt + 16'd1;
      end
      if ((|flush) && (flush_cnt != 16'hFFFF)) begin
        flush_cnt <= flush_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// tb_ctrl_pipe_chain
//   Self-checking bench for ctrl_pipe_chain (WIDTH=31, DEPTH=3,
//   COND_STAGE=0, KILL_MASK='hB). A behavioural model tracks the pipe as
//   arrays of words; each scenario task compares the DUT with it inline.
//   Define CTRL_PIPE_PERF_EN to also exercise the counters.
module tb_ctrl_pipe_chain;
  localparam int W = 31;
  localparam int D = 3;
  localparam logic [W-1:0] KM = 31'h0000B;

  logic           clk;
  logic           reset;
  logic           in_valid;
  logic [W-1:0]   in_ctrl;
  logic           in_ready;
  logic [D-1:0]   stall;
  logic [D-1:0]   flush;
  logic           cond_ex;
  logic [D-1:0]   stage_valid;
  logic [D*W-1:0] stage_ctrl;
  logic           out_valid;
  logic [W-1:0]   out_ctrl;
`ifdef CTRL_PIPE_PERF_EN
  logic [15:0]    bubble_cnt;
  logic [15:0]    flush_cnt;
`endif

  int total;
  int bad;

  logic         m_v [D];
  logic [W-1:0] m_c [D];
  int           m_bub;
  int           m_fl;

  ctrl_pipe_chain #(.WIDTH(W), .DEPTH(D), .COND_STAGE(0), .KILL_MASK(KM)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ctrl    (in_ctrl),
    .in_ready   (in_ready),
    .stall      (stall),
    .flush      (flush),
    .cond_ex    (cond_ex),
    .stage_valid(stage_valid),
    .stage_ctrl (stage_ctrl),
    .out_valid  (out_valid),
    .out_ctrl   (out_ctrl)
`ifdef CTRL_PIPE_PERF_EN
    ,
    .bubble_cnt (bubble_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a stage is frozen whenever any stall exists at it or beyond.
  function automatic logic m_hold(input int i);
    return ((stall >> i) != 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin
      m_v[i] = 1'b0;
      m_c[i] = '0;
    end
    m_bub = 0;
    m_fl  = 0;
  endtask

  task automatic model_step();
    logic         nv [D];
    logic [W-1:0] nc [D];
    for (int i = 0; i < D; i++) begin
      if (flush[i]) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else if (m_hold(i)) begin
        nv[i] = m_v[i]; nc[i] = m_c[i];
      end else if (i == 0) begin
        nv[i] = in_valid; nc[i] = in_ctrl;
      end else if (m_hold(i - 1)) begin
        nv[i] = 1'b0; nc[i] = '0;
      end else begin
        nv[i] = m_v[i-1];
        nc[i] = (i == 1 && !cond_ex) ? (m_c[i-1] & ~KM) : m_c[i-1];
      end
    end
    if (flush != 0 && m_fl < 65535) m_fl++;
    if (!flush[D-1] && !m_hold(D - 1) && !nv[D-1] && m_bub < 65535) m_bub++;
    for (int i = 0; i < D; i++) begin
      m_v[i] = nv[i];
      m_c[i] = nc[i];
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_ctrl = '0; stall = '0; flush = '0; cond_ex = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #12;
    total++;
    if (stage_valid !== '0 || stage_ctrl !== '0) begin
      bad++;
      $display("FAIL reset_clear: valid=%b ctrl=%h want 0/0", stage_valid, stage_ctrl);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
    total++;
    if (in_ready !== 1'b1 || stage_valid !== '0 || out_ctrl !== '0) begin
      bad++;
      $display("FAIL reset_release: ready=%b valid=%b out=%h want 1/000/0", in_ready, stage_valid, out_ctrl);
    end
  endtask

  task automatic test_stream();
    idle_inputs();
    for (int k = 1; k <= 7; k++) begin
      in_valid = (k <= 4);
      in_ctrl  = (k <= 4) ? W'(k) : '0;
      tick();
      if (k >= 3 && k <= 6) begin
        total++;
        if (out_valid !== 1'b1 || out_ctrl !== W'(k - 2)) begin
          bad++;
          $display("FAIL stream_out%0d: got v=%b c=%h want v=1 c=%h", k, out_valid, out_ctrl, W'(k - 2));
        end
      end
    end
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL stream_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_stall();
    int next;
    int got [$];
    idle_inputs();
    next = 1;
    for (int t = 0; t < 16; t++) begin
      stall    = (t == 4 || t == 5) ? 3'b010 : 3'b000;
      in_valid = (next <= 8);
      in_ctrl  = W'(next);
      #1;
      if (stall != 0) begin
        total++;
        if (in_ready !== 1'b0) begin
          bad++;
          $display("FAIL stall_ready: got %b want 0", in_ready);
        end
      end
      if (in_valid && !m_hold(0)) next++;
      tick();
      if (t == 4 || t == 5) begin
        total++;
        if (stage_valid[2] !== 1'b0 || out_ctrl !== '0) begin
          bad++;
          $display("FAIL stall_bubble: got v=%b c=%h want 0/0", stage_valid[2], out_ctrl);
        end
      end
      if (out_valid === 1'b1) got.push_back(int'(out_ctrl));
    end
    total++;
    if (got.size() != 8) begin
      bad++;
      $display("FAIL stall_count: got %0d words want 8", got.size());
    end else begin
      for (int j = 0; j < 8; j++) begin
        total++;
        if (got[j] != j + 1) begin
          bad++;
          $display("FAIL stall_order%0d: got %0d want %0d", j, got[j], j + 1);
        end
      end
    end
  endtask

  task automatic test_flush_stall();
    idle_inputs();
    in_valid = 1'b1;
    in_ctrl = 'h11; tick();
    in_ctrl = 'h22; tick();
    in_ctrl = 'h33; tick();
    in_ctrl = 'h44;
    stall = 3'b010;
    flush = 3'b010;
    tick();
    total++;
    if (stage_valid[1] !== 1'b0 || stage_ctrl[W +: W] !== '0) begin
      bad++;
      $display("FAIL flush_beats_stall: got v=%b c=%h want 0/0", stage_valid[1], stage_ctrl[W +: W]);
    end
    total++;
    if (stage_valid[0] !== 1'b1 || stage_ctrl[0 +: W] !== W'('h33)) begin
      bad++;
      $display("FAIL flush_s0_hold: got v=%b c=%h want 1/33", stage_valid[0], stage_ctrl[0 +: W]);
    end
    total++;
    if (stage_valid[2] !== 1'b0 || out_ctrl !== '0) begin
      bad++;
      $display("FAIL flush_s2_bubble: got v=%b c=%h want 0/0", stage_valid[2], out_ctrl);
    end
  endtask

  task automatic test_cond_kill();
    for (int pass = 0; pass < 2; pass++) begin
      idle_inputs();
      flush = 3'b111;
      tick();
      flush = '0;
      in_valid = 1'b1;
      in_ctrl  = 'h0000F;
      tick();
      in_valid = 1'b0;
      in_ctrl  = '0;
      cond_ex  = (pass == 1);
      tick();
      total++;
      if (stage_valid[1] !== 1'b1 || stage_ctrl[W +: W] !== ((pass == 1) ? W'('hF) : W'('h4))) begin
        bad++;
        $display("FAIL cond_kill%0d: got v=%b c=%h want 1/%h", pass, stage_valid[1],
                 stage_ctrl[W +: W], (pass == 1) ? W'('hF) : W'('h4));
      end
    end
  endtask

  task automatic test_async_reset();
    idle_inputs();
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_ctrl = W'('h100 + k);
      tick();
    end
    stall = 3'b111;
    tick();
    total++;
    if (stage_valid !== 3'b111) begin
      bad++;
      $display("FAIL areset_full: got %b want 111", stage_valid);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    total++;
    if (stage_valid !== '0 || stage_ctrl !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL areset_clear: valid=%b ctrl=%h want 0/0", stage_valid, stage_ctrl);
    end
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < D; i++) begin
        stall[i] = ($urandom % 5 == 0);
        flush[i] = ($urandom % 10 == 0);
      end
      in_valid = ($urandom % 4 != 0);
      in_ctrl  = W'($urandom);
      cond_ex  = $urandom % 2;
      #1;
      total++;
      if (in_ready !== !m_hold(0)) begin
        bad++;
        $display("FAIL rand_ready t%0d: got %b want %b", t, in_ready, !m_hold(0));
      end
      tick();
      for (int i = 0; i < D; i++) begin
        total++;
        if (stage_valid[i] !== m_v[i] || stage_ctrl[i*W +: W] !== m_c[i]) begin
          bad++;
          $display("FAIL rand_stage%0d t%0d: got v=%b c=%h want v=%b c=%h", i, t,
                   stage_valid[i], stage_ctrl[i*W +: W], m_v[i], m_c[i]);
        end
      end
      total++;
      if (out_valid !== m_v[D-1] || out_ctrl !== m_c[D-1]) begin
        bad++;
        $display("FAIL rand_out t%0d: got v=%b c=%h want v=%b c=%h", t, out_valid, out_ctrl, m_v[D-1], m_c[D-1]);
      end
    end
    idle_inputs();
  endtask

`ifdef CTRL_PIPE_PERF_EN
  task automatic test_perf();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    flush = 3'b001;
    for (int k = 0; k < 3; k++) tick();
    flush = '0;
    total++;
    if (flush_cnt !== 16'd3) begin
      bad++;
      $display("FAIL perf_flush: got %0d want 3", flush_cnt);
    end
    total++;
    if (bubble_cnt !== 16'd3) begin
      bad++;
      $display("FAIL perf_bubble_early: got %0d want 3", bubble_cnt);
    end
    for (int k = 0; k < 65540; k++) tick();
    total++;
    if (bubble_cnt !== 16'hFFFF || flush_cnt !== 16'd3) begin
      bad++;
      $display("FAIL perf_saturate: bubble=%h flush=%0d want FFFF/3", bubble_cnt, flush_cnt);
    end
  endtask
`endif

  initial begin
    total = 0;
    bad   = 0;
    idle_inputs();
    reset = 1'b0;
    model_reset();
    test_reset();
    test_stream();
    test_stall();
    test_flush_stall();
    test_cond_kill();
    test_async_reset();
    test_random();
`ifdef CTRL_PIPE_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
